syndrome_calc: RTL and testbench

- Upstream neighbour of the decoder's error-correction stage: computes the 5-bit syndrome S and the error-count code NOF for each received codeword.
- Forwards the aligned codeword, mode flags, S and NOF to the correction stage.
- Two-stage valid/ready pipeline with backpressure, plus saturating single/double-error statistics counters readable by the register block.

---
 rtl/syndrome_calc.sv | 152 +++++++++++++++
 tb/tb_syndrome_calc.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/syndrome_calc.sv
`default_nettype none
// ---------------------------------------------------------------------------
// syndrome_calc : two-stage syndrome / error-count pipeline with counters
// Revision 1.0
// ---------------------------------------------------------------------------
module syndrome_calc #(
  parameter int AMBA_WORD = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [AMBA_WORD-1:0] in_data,
  input  logic                 in_small,
  input  logic                 in_medium,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [AMBA_WORD-1:0] out_data,
  output logic                 out_small,
  output logic                 out_medium,
  output logic [4:0]           S,
  output logic [1:0]           NOF,
  input  logic                 cnt_clear,
  output logic [CNT_WIDTH-1:0] single_cnt,
  output logic [CNT_WIDTH-1:0] double_cnt
);

  localparam logic [CNT_WIDTH-1:0] c_cnt_max    = '1;
  localparam logic [AMBA_WORD-1:0] c_mask_small = AMBA_WORD'(32'h0000_00FF);
  localparam logic [AMBA_WORD-1:0] c_mask_med   = AMBA_WORD'(32'h0000_FFFF);
  localparam logic [1:0]           c_nof_none   = 2'b00;
  localparam logic [1:0]           c_nof_single = 2'b01;
  localparam logic [1:0]           c_nof_double = 2'b10;

  // Data bits take the non-power-of-two values in ascending order.
  function automatic logic [4:0] h_col(input int k);
    int v;
    if (k < 5) return 5'(1 << k);
    if (k == 5) return 5'd0;
    v = 2;
    for (int i = 0; i < k - 5; i++) begin
      v = v + 1;
      if (v == 4 || v == 8 || v == 16) v = v + 1;
    end
    return v[4:0];
  endfunction

  logic                 r_s1_valid;
  logic [AMBA_WORD-1:0] r_s1_data;
  logic                 r_s1_small;
  logic                 r_s1_medium;

  logic                 r_out_valid;
  logic [AMBA_WORD-1:0] r_out_data;
  logic                 r_out_small;
  logic                 r_out_medium;
  logic [4:0]           r_syn;
  logic [1:0]           r_nof;
  logic [CNT_WIDTH-1:0] r_single_cnt;
  logic [CNT_WIDTH-1:0] r_double_cnt;

  logic                 w_s2_advance;
  logic                 w_in_fire;
  logic                 w_out_fire;
  logic [AMBA_WORD-1:0] w_masked;
  logic [4:0]           w_syn;
  logic                 w_par;
  logic [1:0]           w_nof;

  assign w_s2_advance = !r_out_valid || out_ready;
  assign in_ready     = !r_s1_valid || w_s2_advance;
  assign w_in_fire    = in_valid && in_ready;
  assign w_out_fire   = r_out_valid && out_ready;

  always_comb begin
    w_masked = in_data;
    if (in_small)       w_masked = in_data & c_mask_small;
    else if (in_medium) w_masked = in_data & c_mask_med;
  end

  always_comb begin
    w_syn = 5'd0;
    for (int k = 0; k < AMBA_WORD; k++) begin
      if (r_s1_data[k]) w_syn = w_syn ^ h_col(k);
    end
    w_par = ^r_s1_data;
    if (w_par)              w_nof = c_nof_single;
    else if (w_syn == 5'd0) w_nof = c_nof_none;
    else                    w_nof = c_nof_double;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid  <= 1'b0;
      r_s1_data   <= '0;
      r_s1_small  <= 1'b0;
      r_s1_medium <= 1'b0;
    end else if (in_ready) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_data   <= w_masked;
        r_s1_small  <= in_small;
        r_s1_medium <= in_medium && !in_small;
      end
    end
  end

  // Payload only moves on a real word so a bubble never disturbs held fields.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_out_small  <= 1'b0;
      r_out_medium <= 1'b0;
      r_syn        <= 5'd0;
      r_nof        <= c_nof_none;
    end else if (w_s2_advance) begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_out_data   <= r_s1_data;
        r_out_small  <= r_s1_small;
        r_out_medium <= r_s1_medium;
        r_syn        <= w_syn;
        r_nof        <= w_nof;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || cnt_clear) begin
      r_single_cnt <= '0;
      r_double_cnt <= '0;
    end else if (w_out_fire) begin
      if (r_nof == c_nof_single && r_single_cnt != c_cnt_max)
        r_single_cnt <= r_single_cnt + 1'b1;
      if (r_nof == c_nof_double && r_double_cnt != c_cnt_max)
        r_double_cnt <= r_double_cnt + 1'b1;
    end
  end

  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign out_small  = r_out_small;
  assign out_medium = r_out_medium;
  assign S          = r_syn;
  assign NOF        = r_nof;
  assign single_cnt = r_single_cnt;
  assign double_cnt = r_double_cnt;

endmodule
`default_nettype wire

// File: tb/tb_syndrome_calc.sv
`default_nettype none
// Directed testbench for syndrome_calc.
module tb_syndrome_calc;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_small;
  logic        in_medium;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_small;
  logic        out_medium;
  logic [4:0]  S;
  logic [1:0]  NOF;
  logic        cnt_clear;
  logic [15:0] single_cnt;
  logic [15:0] double_cnt;

  int total = 0;
  int bad   = 0;

  syndrome_calc #(.AMBA_WORD(32), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_small(in_small), .in_medium(in_medium),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_small(out_small), .out_medium(out_medium),
    .S(S), .NOF(NOF),
    .cnt_clear(cnt_clear), .single_cnt(single_cnt), .double_cnt(double_cnt)
  );

  always #5 clk = ~clk;

  // Stimulus helper: sends one word with out_ready=1, returns the result fields.
  task automatic run_word(input logic [31:0] d, input logic sm, input logic md,
                          output logic [31:0] od, output logic [4:0] os,
                          output logic [1:0] on, output logic osm,
                          output logic omd, output int lat);
    in_data = d; in_small = sm; in_medium = md; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (lat < 10) begin
      @(negedge clk);
      if (out_valid) break;
      @(posedge clk); #1;
      lat++;
    end
    od = out_data; os = S; on = NOF; osm = out_small; omd = out_medium;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 0; in_data = 0; in_small = 0; in_medium = 0;
    out_ready = 1'b1; cnt_clear = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    total++; if (out_data !== 32'h0) begin bad++; $display("FAIL reset_out_data got=%h want=0", out_data); end
    total++; if ({S, NOF, out_small, out_medium} !== 9'h0) begin bad++; $display("FAIL reset_fields got S=%b NOF=%b sm=%b md=%b want 0", S, NOF, out_small, out_medium); end
    total++; if ({single_cnt, double_cnt} !== 32'h0) begin bad++; $display("FAIL reset_counters got %h/%h want 0/0", single_cnt, double_cnt); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_clean();
    logic [31:0] od; logic [4:0] os; logic [1:0] on; logic osm, omd; int lat;
    run_word(32'h0, 0, 0, od, os, on, osm, omd, lat);
    total++; if (lat !== 2) begin bad++; $display("FAIL clean_latency got=%0d want=2", lat); end
    total++; if ({od, os, on} !== 39'h0) begin bad++; $display("FAIL clean_word got data=%h S=%b NOF=%b want 0/00000/00", od, os, on); end
    total++; if ({single_cnt, double_cnt} !== 32'h0) begin bad++; $display("FAIL clean_counters got %h/%h want 0/0", single_cnt, double_cnt); end
  endtask

  task automatic test_single();
    logic [31:0] od; logic [4:0] os; logic [1:0] on; logic osm, omd; int lat;
    run_word(32'h0000_0040, 0, 0, od, os, on, osm, omd, lat);
    total++; if ({os, on} !== {5'b00011, 2'b01}) begin bad++; $display("FAIL single_bit6 got S=%b NOF=%b want 00011/01", os, on); end
    total++; if (single_cnt !== 16'd1) begin bad++; $display("FAIL single_cnt1 got=%0d want=1", single_cnt); end
    run_word(32'h0000_0020, 0, 0, od, os, on, osm, omd, lat);
    total++; if ({os, on} !== {5'b00000, 2'b01}) begin bad++; $display("FAIL single_bit5 got S=%b NOF=%b want 00000/01", os, on); end
    run_word(32'h8000_0000, 0, 0, od, os, on, osm, omd, lat);
    total++; if ({os, on} !== {5'b11111, 2'b01}) begin bad++; $display("FAIL single_bit31 got S=%b NOF=%b want 11111/01", os, on); end
    total++; if (single_cnt !== 16'd3) begin bad++; $display("FAIL single_cnt3 got=%0d want=3", single_cnt); end
  endtask

  task automatic test_double();
    logic [31:0] od; logic [4:0] os; logic [1:0] on; logic osm, omd; int lat;
    run_word(32'h0000_0003, 0, 0, od, os, on, osm, omd, lat);
    total++; if ({os, on} !== {5'b00011, 2'b10}) begin bad++; $display("FAIL double_bits01 got S=%b NOF=%b want 00011/10", os, on); end
    total++; if ({single_cnt, double_cnt} !== {16'd3, 16'd1}) begin bad++; $display("FAIL double_counters got %0d/%0d want 3/1", single_cnt, double_cnt); end
  endtask

  task automatic test_masking();
    logic [31:0] od; logic [4:0] os; logic [1:0] on; logic osm, omd; int lat;
    run_word(32'hFFFF_0001, 1, 0, od, os, on, osm, omd, lat);
    total++; if (od !== 32'h0000_0001) begin bad++; $display("FAIL small_data got=%h want=00000001", od); end
    total++; if ({os, on, osm, omd} !== {5'b00001, 2'b01, 2'b10}) begin bad++; $display("FAIL small_fields got S=%b NOF=%b sm=%b md=%b want 00001/01/1/0", os, on, osm, omd); end
    run_word(32'h0001_0000, 0, 1, od, os, on, osm, omd, lat);
    total++; if ({od, on} !== 34'h0) begin bad++; $display("FAIL medium_data got data=%h NOF=%b want 0/00", od, on); end
    total++; if ({osm, omd} !== 2'b01) begin bad++; $display("FAIL medium_flags got sm=%b md=%b want 0/1", osm, omd); end
    total++; if ({single_cnt, double_cnt} !== {16'd4, 16'd1}) begin bad++; $display("FAIL masking_counters got %0d/%0d want 4/1", single_cnt, double_cnt); end
  endtask

  task automatic test_backpressure();
    logic [31:0] w_in   [4];
    logic        w_sm   [4];
    logic [31:0] x_data [4];
    logic [4:0]  x_s    [4];
    logic [1:0]  x_nof  [4];
    logic [31:0] g_data [4];
    logic [4:0]  g_s    [4];
    logic [1:0]  g_nof  [4];
    logic        g_sm   [4];
    logic [31:0] hold_d; logic [4:0] hold_s; logic [1:0] hold_n;
    int idx = 0, got = 0, stalled = 0, cyc = 0;
    logic first_seen = 0, acc, unstable = 0;
    w_in[0] = 32'h0000_0040; w_sm[0] = 0; x_data[0] = 32'h0000_0040; x_s[0] = 5'd3;  x_nof[0] = 2'b01;
    w_in[1] = 32'hFFFF_0003; w_sm[1] = 1; x_data[1] = 32'h0000_0003; x_s[1] = 5'd3;  x_nof[1] = 2'b10;
    w_in[2] = 32'h8000_0000; w_sm[2] = 0; x_data[2] = 32'h8000_0000; x_s[2] = 5'd31; x_nof[2] = 2'b01;
    w_in[3] = 32'h0000_0000; w_sm[3] = 0; x_data[3] = 32'h0000_0000; x_s[3] = 5'd0;  x_nof[3] = 2'b00;
    cnt_clear = 1; @(posedge clk); #1 cnt_clear = 0;
    out_ready = 0; in_medium = 0;
    in_valid = 1; in_data = w_in[0]; in_small = w_sm[0];
    while (got < 4 && cyc < 40) begin
      @(negedge clk);
      acc = in_valid && in_ready;
      if (out_valid && !first_seen) begin
        first_seen = 1; hold_d = out_data; hold_s = S; hold_n = NOF;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready_drop got=%b want=0", in_ready); end
      end else if (out_valid && !out_ready) begin
        if (out_data !== hold_d || S !== hold_s || NOF !== hold_n) unstable = 1;
      end
      if (out_valid && out_ready) begin
        g_data[got] = out_data; g_s[got] = S; g_nof[got] = NOF; g_sm[got] = out_small; got++;
      end
      @(posedge clk); #1;
      cyc++;
      if (acc) begin
        idx++;
        if (idx < 4) begin in_data = w_in[idx]; in_small = w_sm[idx]; end
        else in_valid = 0;
      end
      if (first_seen && !out_ready) begin
        stalled++;
        if (stalled == 3) out_ready = 1;
      end
    end
    in_valid = 0; in_small = 0; out_ready = 1;
    total++; if (got !== 4) begin bad++; $display("FAIL bp_word_count got=%0d want=4", got); end
    total++; if (unstable !== 1'b0) begin bad++; $display("FAIL bp_stall_stable got=changed want=stable"); end
    for (int i = 0; i < got; i++) begin
      total++;
      if (g_data[i] !== x_data[i] || g_s[i] !== x_s[i] || g_nof[i] !== x_nof[i] || g_sm[i] !== w_sm[i]) begin
        bad++; $display("FAIL bp_word%0d got data=%h S=%b NOF=%b sm=%b want %h/%b/%b/%b", i, g_data[i], g_s[i], g_nof[i], g_sm[i], x_data[i], x_s[i], x_nof[i], w_sm[i]);
      end
    end
    repeat (2) @(posedge clk); #1;
    total++; if ({single_cnt, double_cnt} !== {16'd2, 16'd1}) begin bad++; $display("FAIL bp_counters got %0d/%0d want 2/1", single_cnt, double_cnt); end
  endtask

  task automatic test_counters();
    logic [31:0] od; logic [4:0] os; logic [1:0] on; logic osm, omd; int lat;
    cnt_clear = 1; @(posedge clk); #1 cnt_clear = 0;
    total++; if ({single_cnt, double_cnt} !== 32'h0) begin bad++; $display("FAIL clear_idle got %h/%h want 0/0", single_cnt, double_cnt); end
    in_data = 32'h0000_0040; in_small = 0; in_medium = 0; in_valid = 1;
    repeat (65535) @(posedge clk);
    #1 in_valid = 0;
    repeat (3) @(posedge clk); #1;
    total++; if (single_cnt !== 16'hFFFF) begin bad++; $display("FAIL sat_reach got=%h want=ffff", single_cnt); end
    run_word(32'h0000_0040, 0, 0, od, os, on, osm, omd, lat);
    total++; if (single_cnt !== 16'hFFFF || on !== 2'b01) begin bad++; $display("FAIL sat_hold got=%h NOF=%b want=ffff/01", single_cnt, on); end
    in_data = 32'h0000_0040; in_valid = 1;
    @(posedge clk); #1 in_valid = 0;
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL clear_coincide_valid got=%b want=1", out_valid); end
    cnt_clear = 1;
    @(posedge clk); #1 cnt_clear = 0;
    total++; if ({single_cnt, double_cnt} !== 32'h0) begin bad++; $display("FAIL clear_coincide got %h/%h want 0/0", single_cnt, double_cnt); end
  endtask

  task automatic test_reset_inflight();
    logic [31:0] od; logic [4:0] os; logic [1:0] on; logic osm, omd; int lat;
    logic seen = 0;
    run_word(32'h0000_0040, 0, 0, od, os, on, osm, omd, lat);
    total++; if (single_cnt !== 16'd1) begin bad++; $display("FAIL pre_rst_cnt got=%0d want=1", single_cnt); end
    in_valid = 1; in_data = 32'h0000_0040;
    @(posedge clk); #1 in_data = 32'h0000_0003;
    @(posedge clk); #1 in_valid = 0;
    rst = 1;
    @(posedge clk); #1 rst = 0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_inflight_valid got=%b want=0", out_valid); end
    total++; if ({single_cnt, double_cnt} !== 32'h0) begin bad++; $display("FAIL rst_inflight_cnt got %h/%h want 0/0", single_cnt, double_cnt); end
    total++; if ({out_data, S, NOF} !== 39'h0) begin bad++; $display("FAIL rst_inflight_fields got data=%h S=%b NOF=%b want 0", out_data, S, NOF); end
    repeat (3) begin @(negedge clk); if (out_valid) seen = 1; end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL rst_discard got=word_emerged want=none"); end
  endtask

  initial begin
    test_reset();
    test_clean();
    test_single();
    test_double();
    test_masking();
    test_backpressure();
    test_counters();
    test_reset_inflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
